booth_operand_sequencer: RTL
============================

Name: booth_operand_sequencer

Overview:
- Upstream feeder for the digit-serial Booth/DAA MAC tile.
- Buffers a job of N_TERMS (activation, weight) pairs through a valid/ready interface.
- Replays the buffer digit-serially: outer loop over radix-4 Booth digits (LSB first), inner loop over terms. Per cycle it drives the PE with InPE, a 3-bit Booth window, NEP, EPcount, enable, clear and sign-extension mode.
- Flags job completion once the PE pipeline has drained.

Parameters:
- N_TERMS, 4, terms per job (1..8).
- W_WIDTH, 8, weight width, even, 2..18. NDIG = W_WIDTH/2 ≤ 9, which matches the 9 save slots.
- DRAIN_CYCLES, 2, idle-digit cycles after the last issue (1..3).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  job beat valid.
- in_ready  out  1  sequencer accepts a beat.
- in_act  in  4  activation for this beat.
- in_wgt  in  W_WIDTH  weight for this beat.
- in_signed  in  1  signed-activation mode, sampled on the first beat of a job.
- pe_inpe  out  4  activation to the PE.
- pe_w  out  3  Booth window to the PE, bit order {x2,x1,x0}.
- pe_nep  out  1  new-partial-product (digit boundary) strobe.
- pe_epcount  out  4  save-slot index = current digit j.
- pe_ena  out  1  PE enable.
- pe_clear  out  1  PE accumulator clear.
- pe_signexen  out  1  latched in_signed.
- busy  out  1  high from CLR through DRAIN.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Storage:
  - Buffer: act_buf[N_TERMS] × 4b and wgt_buf[N_TERMS] × W_WIDTH.
  - Counters: load_cnt, term k, digit j, drain_cnt.
  - Mode flop: sig_q.
- Outputs are Moore: decoded from registered state/counters only, no combinational path from in_valid.
- Reset (async, any time, including mid-load or mid-run):
  - state = LOAD; all counters = 0; sig_q = 0; buffer contents don't-care.
  - Outputs: in_ready = 1; all pe_* = 0; busy = 0; done = 0.
  - Any partial job is discarded.
- LOAD:
  - in_ready = 1, pe_ena = 0, pe_w = 000, pe_nep = 0.
  - On in_valid & in_ready: buf[load_cnt] ← (in_act, in_wgt). On load_cnt == 0, also sig_q ← in_signed.
  - Then load_cnt++. After beat N_TERMS-1 (handshake): load_cnt ← 0, go to CLR.
  - in_valid low: hold state.
- CLR (1 cycle): pe_clear = 1, pe_ena = 1, pe_w = 000, pe_nep = 0, pe_epcount = 0, busy = 1; then → RUN with j = 0, k = 0.
- RUN (NDIG × N_TERMS cycles): pe_ena = 1, busy = 1, in_ready = 0.
  - pe_inpe = act_buf[k].
  - pe_w = {wgt_buf[k][2j+1], wgt_buf[k][2j], wgt_buf[k][2j-1]}, where bit[-1] = 0.
  - pe_epcount = j; pe_nep = (k == N_TERMS-1).
  - Each cycle: k++. On k wrap to 0: j++.
  - After (j = NDIG-1, k = N_TERMS-1) → DRAIN.
- DRAIN (DRAIN_CYCLES cycles): pe_ena = 1, pe_w = 000 (zero digit, no accumulate effect), pe_nep = 0, pe_inpe = 0, busy = 1; then → DONE.
- DONE (1 cycle): done = 1, busy = 0, pe_ena = 0; then → LOAD. in_ready goes high in the next cycle.
- pe_signexen = sig_q at all times; sig_q stays stable from the first beat until the next job's first beat.
- Boundary cases:
  - in_valid asserted outside LOAD is ignored; no beat is consumed.
  - N_TERMS = 1: pe_nep = 1 on every RUN cycle.
  - A weight MSB of 1 yields window 1xx on the top digit (negative digit); no extra digit is generated.
  - Counter wrap is exact: no extra RUN cycle, no skipped digit.
- Throughput:
  - Job cycle count = N_TERMS (min) + 1 + NDIG·N_TERMS + DRAIN_CYCLES + 1.
  - With defaults: 4 + 1 + 16 + 2 + 1 = 24.

Test Plan:
- Reset then idle → in_ready = 1, pe_ena = 0, pe_clear = 0, done = 0, busy = 0. Hold in_valid = 0 for 10 cycles → state unchanged.
- Load 4 beats, wgt = 0x6B each, act = 1,2,3,4, back-to-back → CLR pulse 1 cycle after the 4th beat, then 16 RUN cycles:
  - pe_w per digit: 110, 101, 101, 011 (each held for 4 cycles).
  - pe_inpe cycles 1,2,3,4 within each digit.
  - pe_nep high on RUN cycles 4, 8, 12, 16; pe_epcount 0..3.
  - Then 2 drain cycles, done pulse; total 24 cycles.
- in_valid toggling 1,0,1,0… during load → exactly 4 beats captured in order; CLR follows the 4th handshake. in_signed = 1 on beat 0 and 0 on later beats → pe_signexen = 1 for the whole job.
- wgt = 0x80 (−128), single term (N_TERMS = 1) → pe_w = 000, 000, 000, 100; pe_nep = 1 every RUN cycle.
- Assert rst during RUN cycle 7 → same/next edge: pe_ena = 0, in_ready = 1, busy = 0, no done pulse. A new 4-beat job then completes normally in 24 cycles.
- in_valid held high during RUN/DRAIN/DONE with changing data → no beats consumed; the next job's buffer holds only beats presented while in_ready = 1.

Source files
------------

// File: rtl/booth_operand_sequencer.sv
// rtl/booth_operand_sequencer.sv - job buffer and digit-serial Booth operand replay for the MAC tile
//
// Purpose: accepts a job of N_TERMS (activation, weight) beats, then replays it
// digit-serially to the Booth/DAA PE: outer loop over radix-4 Booth digits
// (LSB first), inner loop over terms. It issues an accumulator clear first,
// runs idle drain cycles at the end, and pulses done.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   in_valid/in_ready job beat handshake; in_act, in_wgt, in_signed beat data
//   pe_inpe           activation for the current term
//   pe_w              Booth window {x2,x1,x0} of the current digit
//   pe_nep            last term of a digit (digit boundary)
//   pe_epcount        current digit index (PE save slot)
//   pe_ena, pe_clear  PE enable and accumulator clear
//   pe_signexen       signed-activation mode of the current job
//   busy, done        job in progress (CLR..DRAIN), one-cycle completion pulse
module booth_operand_sequencer #(
  parameter int N_TERMS      = 4,
  parameter int W_WIDTH      = 8,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         in_act,
  input  logic [W_WIDTH-1:0] in_wgt,
  input  logic               in_signed,
  output logic [3:0]         pe_inpe,
  output logic [2:0]         pe_w,
  output logic               pe_nep,
  output logic [3:0]         pe_epcount,
  output logic               pe_ena,
  output logic               pe_clear,
  output logic               pe_signexen,
  output logic               busy,
  output logic               done
);

  localparam int NDIG = W_WIDTH / 2;
  // Term index width; a one-term job still gets a 1-bit counter.
  localparam int KW = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N_TERMS - 1);
  localparam logic [3:0]    J_LAST = 4'(NDIG - 1);
  localparam logic [1:0]    D_LAST = 2'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {S_LOAD, S_CLR, S_RUN, S_DRAIN, S_DONE} state_e;

  logic [3:0]         act_buf [0:(1<<KW)-1];
  logic [W_WIDTH-1:0] wgt_buf [0:(1<<KW)-1];

  state_e        state_q, state_d;
  logic [KW-1:0] load_q, load_d;
  logic [KW-1:0] k_q, k_d;
  logic [3:0]    j_q, j_d;
  logic [1:0]    drain_q, drain_d;
  logic          sig_q, sig_d;
  logic          hs;
  logic [W_WIDTH:0] ext_w;
  logic [2:0]    win_d;

  logic       in_ready_q, pe_nep_q, pe_ena_q, pe_clear_q, busy_q, done_q;
  logic [3:0] pe_inpe_q, pe_epcount_q;
  logic [2:0] pe_w_q;

  // in_ready is high exactly in LOAD, so a LOAD beat with in_valid is a handshake.
  assign hs = (state_q == S_LOAD) && in_valid;

  always_comb begin
    state_d = state_q;
    load_d  = load_q;
    k_d     = k_q;
    j_d     = j_q;
    drain_d = drain_q;
    sig_d   = sig_q;
    case (state_q)
      S_LOAD: begin
        if (hs) begin
          if (load_q == '0) sig_d = in_signed;
          if (load_q == K_LAST) begin
            load_d  = '0;
            state_d = S_CLR;
          end else begin
            load_d = load_q + 1'b1;
          end
        end
      end
      S_CLR: begin
        k_d     = '0;
        j_d     = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (k_q == K_LAST) begin
          k_d = '0;
          if (j_q == J_LAST) begin
            j_d     = '0;
            drain_d = '0;
            state_d = S_DRAIN;
          end else begin
            j_d = j_q + 1'b1;
          end
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (drain_q == D_LAST) begin
          drain_d = '0;
          state_d = S_DONE;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_LOAD;
      default: state_d = S_LOAD;
    endcase
  end

  // Window for the upcoming (k, j): weight shifted left by one supplies the
  // implicit bit[-1] = 0, so digit j is bits [2j+2 : 2j] of the extended word.
  always_comb begin
    ext_w = {wgt_buf[k_d], 1'b0};
    win_d = 3'(ext_w >> {j_d, 1'b0});
  end

  always_ff @(posedge clk) begin
    if (hs) begin
      act_buf[load_q] <= in_act;
      wgt_buf[load_q] <= in_wgt;
    end
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_LOAD;
      load_q       <= '0;
      k_q          <= '0;
      j_q          <= '0;
      drain_q      <= '0;
      sig_q        <= 1'b0;
      in_ready_q   <= 1'b1;
      pe_inpe_q    <= '0;
      pe_w_q       <= '0;
      pe_nep_q     <= 1'b0;
      pe_epcount_q <= '0;
      pe_ena_q     <= 1'b0;
      pe_clear_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      load_q       <= load_d;
      k_q          <= k_d;
      j_q          <= j_d;
      drain_q      <= drain_d;
      sig_q        <= sig_d;
      in_ready_q   <= (state_d == S_LOAD);
      pe_inpe_q    <= (state_d == S_RUN) ? act_buf[k_d] : 4'd0;
      pe_w_q       <= (state_d == S_RUN) ? win_d : 3'd0;
      pe_nep_q     <= (state_d == S_RUN) && (k_d == K_LAST);
      pe_epcount_q <= (state_d == S_RUN) ? j_d : 4'd0;
      pe_ena_q     <= (state_d == S_CLR) || (state_d == S_RUN) || (state_d == S_DRAIN);
      pe_clear_q   <= (state_d == S_CLR);
      busy_q       <= (state_d == S_CLR) || (state_d == S_RUN) || (state_d == S_DRAIN);
      done_q       <= (state_d == S_DONE);
    end
  end

  assign in_ready    = in_ready_q;
  assign pe_inpe     = pe_inpe_q;
  assign pe_w        = pe_w_q;
  assign pe_nep      = pe_nep_q;
  assign pe_epcount  = pe_epcount_q;
  assign pe_ena      = pe_ena_q;
  assign pe_clear    = pe_clear_q;
  assign pe_signexen = sig_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
